// File: rtl/i2c_slave_target.sv
// rtl/i2c_slave_target.sv - I2C target: address match, write receive, stretched read serve
// Bus lines pass a 2-FF synchroniser and a stability filter; every bus drive comes from a register.
module i2c_slave_target #(
  parameter logic [6:0] ADDR     = 7'h50,
  parameter int         DEGLITCH = 3
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        sda,
  inout  wire        scl,
  input  logic       accept,
  input  logic       send,
  input  logic [7:0] datasend,
  output logic       sendreq,
  output logic [7:0] datareceive,
  output logic       received,
  output logic       selected,
  output logic       rw,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_RX        = 4'd3,
    S_RX_ACK    = 4'd4,
    S_TX_LOAD   = 4'd5,
    S_TX        = 4'd6,
    S_TX_ACK    = 4'd7,
    S_WAIT_STOP = 4'd8
  } state_t;

  localparam logic [3:0] FILT_LAST = 4'(DEGLITCH - 1);

  logic       r_scl_s1, r_scl_s2, r_scl_f, r_scl_p;
  logic       r_sda_s1, r_sda_s2, r_sda_f, r_sda_p;
  logic [3:0] r_scl_cnt, r_sda_cnt;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_full, w_full_nxt;
  logic       r_sda_low, w_sda_low_nxt;
  logic       r_scl_low, w_scl_low_nxt;
  logic       r_sendreq, w_sendreq_nxt;
  logic       r_received, w_received_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_selected, w_selected_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_acked, w_acked_nxt;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [2:0] w_cnt_m1;

  assign sda = r_sda_low ? 1'b0 : 1'bz;
  assign scl = r_scl_low ? 1'b0 : 1'bz;

  // Filtered level only follows the synchronised level after DEGLITCH consecutive differing cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_f <= 1'b1; r_scl_p <= 1'b1; r_scl_cnt <= 4'd0;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_f <= 1'b1; r_sda_p <= 1'b1; r_sda_cnt <= 4'd0;
    end else begin
      r_scl_s1 <= scl;  r_scl_s2 <= r_scl_s1; r_scl_p <= r_scl_f;
      r_sda_s1 <= sda;  r_sda_s2 <= r_sda_s1; r_sda_p <= r_sda_f;
      if (r_scl_s2 == r_scl_f) begin
        r_scl_cnt <= 4'd0;
      end else if (r_scl_cnt == FILT_LAST) begin
        r_scl_f   <= r_scl_s2;
        r_scl_cnt <= 4'd0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 4'd1;
      end
      if (r_sda_s2 == r_sda_f) begin
        r_sda_cnt <= 4'd0;
      end else if (r_sda_cnt == FILT_LAST) begin
        r_sda_f   <= r_sda_s2;
        r_sda_cnt <= 4'd0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 4'd1;
      end
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_p;
  assign w_scl_fall = ~r_scl_f & r_scl_p;
  assign w_start    = r_scl_f & r_scl_p & r_sda_p & ~r_sda_f;
  assign w_stop     = r_scl_f & r_scl_p & ~r_sda_p & r_sda_f;
  assign w_cnt_m1   = r_cnt - 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd7;
      r_shift    <= 8'd0;
      r_full     <= 1'b0;
      r_sda_low  <= 1'b0;
      r_scl_low  <= 1'b0;
      r_sendreq  <= 1'b0;
      r_received <= 1'b0;
      r_data     <= 8'd0;
      r_selected <= 1'b0;
      r_rw       <= 1'b0;
      r_acked    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_full     <= w_full_nxt;
      r_sda_low  <= w_sda_low_nxt;
      r_scl_low  <= w_scl_low_nxt;
      r_sendreq  <= w_sendreq_nxt;
      r_received <= w_received_nxt;
      r_data     <= w_data_nxt;
      r_selected <= w_selected_nxt;
      r_rw       <= w_rw_nxt;
      r_acked    <= w_acked_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_full_nxt     = r_full;
    w_sda_low_nxt  = r_sda_low;
    w_scl_low_nxt  = r_scl_low;
    w_sendreq_nxt  = 1'b0;
    w_received_nxt = 1'b0;
    w_data_nxt     = r_data;
    w_selected_nxt = r_selected;
    w_rw_nxt       = r_rw;
    w_acked_nxt    = r_acked;

    if (w_stop) begin
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = 3'd7;
      w_full_nxt     = 1'b0;
      w_sda_low_nxt  = 1'b0;
      w_scl_low_nxt  = 1'b0;
      w_selected_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt    = S_ADDR;
      w_cnt_nxt      = 3'd7;
      w_full_nxt     = 1'b0;
      w_sda_low_nxt  = 1'b0;
      w_scl_low_nxt  = 1'b0;
      w_selected_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise && !r_full) begin
            w_shift_nxt = {r_shift[6:0], r_sda_f};
            if (r_cnt == 3'd0) begin
              w_full_nxt = 1'b1;
              w_rw_nxt   = r_sda_f;
            end else begin
              w_cnt_nxt = w_cnt_m1;
            end
          end else if (w_scl_fall && r_full) begin
            w_full_nxt = 1'b0;
            w_cnt_nxt  = 3'd7;
            if (r_shift[7:1] == ADDR) begin
              w_sda_low_nxt  = 1'b1;
              w_selected_nxt = 1'b1;
              w_state_nxt    = S_ADDR_ACK;
            end else begin
              w_state_nxt = S_WAIT_STOP;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_sda_low_nxt = 1'b0;
            if (r_rw) begin
              w_state_nxt   = S_TX_LOAD;
              w_sendreq_nxt = 1'b1;
              w_scl_low_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RX;
            end
          end
        end
        S_RX: begin
          if (w_scl_rise && !r_full) begin
            w_shift_nxt = {r_shift[6:0], r_sda_f};
            if (r_cnt == 3'd0) begin
              w_full_nxt     = 1'b1;
              w_data_nxt     = {r_shift[6:0], r_sda_f};
              w_received_nxt = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_m1;
            end
          end else if (w_scl_fall && r_full) begin
            w_full_nxt    = 1'b0;
            w_cnt_nxt     = 3'd7;
            w_sda_low_nxt = accept;
            w_acked_nxt   = accept;
            w_state_nxt   = S_RX_ACK;
          end
        end
        S_RX_ACK: begin
          if (w_scl_fall) begin
            w_sda_low_nxt = 1'b0;
            if (r_acked) begin
              w_state_nxt = S_RX;
            end else begin
              w_state_nxt    = S_WAIT_STOP;
              w_selected_nxt = 1'b0;
            end
          end
        end
        S_TX_LOAD: begin
          if (send) begin
            w_shift_nxt   = datasend;
            w_cnt_nxt     = 3'd7;
            w_sda_low_nxt = ~datasend[7];
            w_scl_low_nxt = 1'b0;
            w_state_nxt   = S_TX;
          end
        end
        S_TX: begin
          if (w_scl_fall) begin
            if (r_cnt == 3'd0) begin
              w_sda_low_nxt = 1'b0;
              w_cnt_nxt     = 3'd7;
              w_state_nxt   = S_TX_ACK;
            end else begin
              w_cnt_nxt     = w_cnt_m1;
              w_sda_low_nxt = ~r_shift[w_cnt_m1];
            end
          end
        end
        S_TX_ACK: begin
          if (w_scl_rise) begin
            w_acked_nxt = ~r_sda_f;
          end else if (w_scl_fall) begin
            if (r_acked) begin
              w_state_nxt   = S_TX_LOAD;
              w_sendreq_nxt = 1'b1;
              w_scl_low_nxt = 1'b1;
            end else begin
              w_state_nxt    = S_WAIT_STOP;
              w_selected_nxt = 1'b0;
            end
          end
        end
        default: begin
          w_sda_low_nxt = 1'b0;
          w_scl_low_nxt = 1'b0;
        end
      endcase
    end
  end

  assign sendreq     = r_sendreq;
  assign datareceive = r_data;
  assign received    = r_received;
  assign selected    = r_selected;
  assign rw          = r_rw;
  assign state       = r_state;

endmodule

// File: tb/tb_i2c_slave_target.sv
// tb/tb_i2c_slave_target.sv - directed bench for i2c_slave_target with an open-drain bus master model
module tb_i2c_slave_target;

  localparam int Q = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       accept;
  logic       send;
  logic [7:0] datasend;
  logic       m_sda_low, m_scl_low;
  wire        sda, scl;
  logic       sendreq, received, selected, rw;
  logic [7:0] datareceive;
  logic [3:0] state;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  assign scl = m_scl_low ? 1'b0 : 1'bz;
  pullup (sda);
  pullup (scl);

  i2c_slave_target #(.ADDR(7'h50), .DEGLITCH(3)) dut (
    .clk(clk), .reset(reset_n), .sda(sda), .scl(scl),
    .accept(accept), .send(send), .datasend(datasend),
    .sendreq(sendreq), .datareceive(datareceive), .received(received),
    .selected(selected), .rw(rw), .state(state)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int max_low = 0;
  int rx_cnt = 0;
  int req_cnt = 0;
  int host_delay = 0;
  bit dut_drove = 1'b0;
  logic [7:0] wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] host_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: received bytes are popped against what the master wrote.
  always @(negedge clk) begin
    if (reset_n) begin
      if (received) begin
        rx_cnt++;
        check("rx_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) check("rx_data", 32'(datareceive), 32'(wr_q.pop_front()));
      end
      if (sendreq) req_cnt++;
      if (!m_sda_low && sda === 1'b0) dut_drove = 1'b1;
    end
  end

  // Host logic answering read requests after host_delay cycles.
  initial begin
    send = 1'b0;
    datasend = 8'h00;
    forever begin
      @(negedge clk);
      if (sendreq) begin
        repeat (host_delay) @(negedge clk);
        datasend = (host_q.size() != 0) ? host_q.pop_front() : 8'h00;
        rd_q.push_back(datasend);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_low();
    m_scl_low = 1'b1;
    fall_cyc  = cyc;
  endtask

  task automatic scl_high();
    int n;
    m_scl_low = 1'b0;
    @(negedge clk);
    n = 1;
    while (scl !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("scl_release", 32'd0, 32'd1);
    if (cyc - fall_cyc > max_low) max_low = cyc - fall_cyc;
  endtask

  task automatic i2c_start();
    wait_clk(Q); m_sda_low = 1'b0; wait_clk(Q);
    scl_high(); wait_clk(Q);
    m_sda_low = 1'b1; wait_clk(2*Q);
    scl_low(); wait_clk(Q);
  endtask

  task automatic i2c_stop();
    wait_clk(Q); m_sda_low = 1'b1; wait_clk(Q);
    scl_high(); wait_clk(Q);
    m_sda_low = 1'b0; wait_clk(2*Q);
  endtask

  task automatic bit_out(input logic b);
    wait_clk(Q); m_sda_low = !b; wait_clk(Q);
    scl_high(); wait_clk(2*Q);
    scl_low();
  endtask

  task automatic bit_in(output logic b);
    wait_clk(Q); m_sda_low = 1'b0; wait_clk(Q);
    scl_high(); wait_clk(Q);
    b = (sda === 1'b1);
    wait_clk(Q);
    scl_low();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(b);
    ack = !b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(!ack);
  endtask

  task automatic rd_check(input logic [7:0] d);
    logic [31:0] exp;
    exp = (rd_q.size() != 0) ? 32'(rd_q.pop_front()) : 32'h100;
    check("rd_data", 32'(d), exp);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         rx0, req0;

    m_sda_low = 1'b0;
    m_scl_low = 1'b0;
    accept    = 1'b1;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    wait_clk(5);
    check("rst_state", 32'(state), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_outs", 32'({sendreq, received, selected, rw}), 32'd0);
    check("rst_data", 32'(datareceive), 32'd0);
    reset_n = 1'b1;
    wait_clk(5);

    // Write 0xA5 to own address
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, a);
    check("wr_addr_ack", 32'(a), 32'd1);
    check("wr_selected", 32'(selected), 32'd1);
    check("wr_rw", 32'(rw), 32'd0);
    wr_q.push_back(8'hA5);
    write_byte(8'hA5, a);
    check("wr_data_ack", 32'(a), 32'd1);
    i2c_stop();
    wait_clk(2*Q);
    check("wr_idle", 32'(state), 32'd0);
    check("wr_unselected", 32'(selected), 32'd0);
    check("wr_rx_pulses", 32'(rx_cnt - rx0), 32'd1);

    // Foreign address
    rx0 = rx_cnt; req0 = req_cnt; dut_drove = 1'b0;
    i2c_start();
    write_byte(8'hA2, a);
    check("mm_addr_nack", 32'(a), 32'd0);
    wait_clk(Q);
    check("mm_wait_stop", 32'(state), 32'd8);
    write_byte(8'h11, a);
    check("mm_data_nack", 32'(a), 32'd0);
    i2c_stop();
    wait_clk(2*Q);
    check("mm_idle", 32'(state), 32'd0);
    check("mm_never_drove", 32'(dut_drove), 32'd0);
    check("mm_no_rx", 32'(rx_cnt - rx0), 32'd0);
    check("mm_no_req", 32'(req_cnt - req0), 32'd0);

    // Read 0x3C with slow host -> stretch
    host_delay = 40; host_q.push_back(8'h3C); req0 = req_cnt;
    i2c_start();
    write_byte(8'hA1, a);
    check("rd_addr_ack", 32'(a), 32'd1);
    check("rd_rw", 32'(rw), 32'd1);
    max_low = 0;
    read_byte(d, 1'b0);
    rd_check(d);
    check("rd_byte_3c", 32'(d), 32'h3C);
    check("rd_stretch40", 32'(max_low >= 40), 32'd1);
    wait_clk(Q);
    check("rd_nack_wait", 32'(state), 32'd8);
    check("rd_unselected", 32'(selected), 32'd0);
    i2c_stop();
    wait_clk(2*Q);
    check("rd_idle", 32'(state), 32'd0);
    check("rd_one_req", 32'(req_cnt - req0), 32'd1);

    // Two-byte read: master ACK then NACK
    host_delay = 3; host_q.push_back(8'h12); host_q.push_back(8'h34); req0 = req_cnt;
    i2c_start();
    write_byte(8'hA1, a);
    check("rd2_addr_ack", 32'(a), 32'd1);
    read_byte(d, 1'b1);
    rd_check(d);
    read_byte(d, 1'b0);
    rd_check(d);
    check("rd2_last_34", 32'(d), 32'h34);
    i2c_stop();
    wait_clk(2*Q);
    check("rd2_two_req", 32'(req_cnt - req0), 32'd2);
    check("rd2_idle", 32'(state), 32'd0);

    // Data NACK with accept=0
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, a);
    check("na_addr_ack", 32'(a), 32'd1);
    accept = 1'b0;
    wr_q.push_back(8'h77);
    write_byte(8'h77, a);
    check("na_data_nack", 32'(a), 32'd0);
    wait_clk(Q);
    check("na_wait_stop", 32'(state), 32'd8);
    check("na_unselected", 32'(selected), 32'd0);
    check("na_rx_pulse", 32'(rx_cnt - rx0), 32'd1);
    i2c_stop();
    accept = 1'b1;
    wait_clk(2*Q);

    // Repeated START part-way through a write byte
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, a);
    check("rs_addr_ack", 32'(a), 32'd1);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
    i2c_start();
    check("rs_in_addr", 32'(state), 32'd1);
    check("rs_no_rx", 32'(rx_cnt - rx0), 32'd0);
    write_byte(8'hA0, a);
    check("rs_readdr_ack", 32'(a), 32'd1);
    wr_q.push_back(8'h5A);
    write_byte(8'h5A, a);
    check("rs_data_ack", 32'(a), 32'd1);
    i2c_stop();
    wait_clk(2*Q);
    check("rs_rx_one", 32'(rx_cnt - rx0), 32'd1);
    check("rs_idle", 32'(state), 32'd0);

    // Reset while presenting a 0 bit
    host_delay = 0; host_q.push_back(8'h00);
    i2c_start();
    write_byte(8'hA1, a);
    check("rst_tx_addr_ack", 32'(a), 32'd1);
    wait_clk(Q); m_sda_low = 1'b0; wait_clk(Q);
    scl_high(); wait_clk(Q);
    check("rst_tx_state", 32'(state), 32'd6);
    check("rst_tx_sda_low", 32'(sda), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx_sda_rel", 32'(sda), 32'd1);
    check("rst_tx_scl_rel", 32'(scl), 32'd1);
    check("rst_tx_state0", 32'(state), 32'd0);
    check("rst_tx_unsel", 32'(selected), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_clk(Q);
    scl_low();
    i2c_stop();
    wait_clk(2*Q);
    check("rst_recover_idle", 32'(state), 32'd0);
    rd_q.delete();
    host_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
